// File: rtl/seg_scan_display.sv
// seg_scan_display: keypad-entry digit buffer with a multiplexed 7-segment scan driver.
//
// New digits enter on the right (d[0]) and push older digits left. Backspace removes the
// newest digit and clear empties the buffer. A prescaler steps a scan index across the
// digits, and one digit is driven per scan slot.
//
// Parameters
//   DIGITS     number of display digits and buffer depth (1..16)
//   SCAN_DIV   clock cycles per scan slot (>= 2)
//   ACTIVE_LOW 1: seg/an active-low, 0: both active-high
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   key_valid  strobe: key_val holds a new hex digit
//   key_val    hex digit being entered
//   backspace  strobe: remove newest digit
//   clear      strobe: empty the buffer
//   seg        registered segment drive {dp,g,f,e,d,c,b,a}
//   an         registered one-hot digit enable
//   count      number of valid digits held
//   overflow   one-cycle pulse when the oldest digit is pushed out
module seg_scan_display #(
  parameter int unsigned DIGITS     = 8,
  parameter int unsigned SCAN_DIV   = 100000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         key_valid,
  input  logic [3:0]                   key_val,
  input  logic                         backspace,
  input  logic                         clear,
  output logic [7:0]                   seg,
  output logic [DIGITS-1:0]            an,
  output logic [$clog2(DIGITS+1)-1:0]  count,
  output logic                         overflow
);

  localparam int unsigned CW = $clog2(DIGITS + 1);
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned PW = $clog2(SCAN_DIV);

  localparam logic [CW-1:0]     CountFull = CW'(DIGITS);
  localparam logic [IW-1:0]     IdxMax    = IW'(DIGITS - 1);
  localparam logic [PW-1:0]     PscMax    = PW'(SCAN_DIV - 1);
  localparam logic [7:0]        SegBlank  = ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] AnReset   = ACTIVE_LOW ? ~DIGITS'(1) : DIGITS'(1);

  // Digit buffer: d[0] is the newest (rightmost) digit.
  logic [3:0]    val_q [DIGITS];
  logic [3:0]    val_d [DIGITS];
  logic          vld_q [DIGITS];
  logic          vld_d [DIGITS];
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic [PW-1:0] psc_q, psc_d;
  logic [IW-1:0] idx_q, idx_d;

  logic [7:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [7:0]        seg_raw;

  // Buffer edits: exactly one operation per cycle, clear > key > backspace.
  always_comb begin
    val_d   = val_q;
    vld_d   = vld_q;
    count_d = count_q;
    ovf_d   = 1'b0;
    if (clear) begin
      for (int i = 0; i < DIGITS; i++) vld_d[i] = 1'b0;
      count_d = '0;
    end else if (key_valid) begin
      for (int i = 1; i < DIGITS; i++) begin
        val_d[i] = val_q[i-1];
        vld_d[i] = vld_q[i-1];
      end
      val_d[0] = key_val;
      vld_d[0] = 1'b1;
      if (count_q == CountFull) begin
        ovf_d = 1'b1;
      end else begin
        count_d = count_q + CW'(1);
      end
    end else if (backspace && (count_q != '0)) begin
      for (int i = 0; i < DIGITS - 1; i++) begin
        val_d[i] = val_q[i+1];
        vld_d[i] = vld_q[i+1];
      end
      vld_d[DIGITS-1] = 1'b0;
      count_d = count_q - CW'(1);
    end
  end

  // Scan timing runs independently of buffer edits.
  always_comb begin
    psc_d = psc_q;
    idx_d = idx_q;
    if (psc_q == PscMax) begin
      psc_d = '0;
      idx_d = (idx_q == IdxMax) ? '0 : idx_q + IW'(1);
    end else begin
      psc_d = psc_q + PW'(1);
    end
  end

  // Active-low segment code of the digit under the scan index; dp kept off.
  always_comb begin
    seg_raw = 8'hFF;
    if (vld_q[idx_q]) begin
      case (val_q[idx_q])
        4'h0:    seg_raw = 8'hC0;
        4'h1:    seg_raw = 8'hF9;
        4'h2:    seg_raw = 8'hA4;
        4'h3:    seg_raw = 8'hB0;
        4'h4:    seg_raw = 8'h99;
        4'h5:    seg_raw = 8'h92;
        4'h6:    seg_raw = 8'h82;
        4'h7:    seg_raw = 8'hF8;
        4'h8:    seg_raw = 8'h80;
        4'h9:    seg_raw = 8'h90;
        4'hA:    seg_raw = 8'h88;
        4'hB:    seg_raw = 8'h83;
        4'hC:    seg_raw = 8'hC6;
        4'hD:    seg_raw = 8'hA1;
        4'hE:    seg_raw = 8'h86;
        default: seg_raw = 8'h8E;
      endcase
    end
  end

  always_comb begin
    seg_d = ACTIVE_LOW ? seg_raw : ~seg_raw;
    an_d  = ACTIVE_LOW ? ~(DIGITS'(1) << idx_q) : (DIGITS'(1) << idx_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DIGITS; i++) begin
        val_q[i] <= 4'h0;
        vld_q[i] <= 1'b0;
      end
      count_q <= '0;
      ovf_q   <= 1'b0;
      psc_q   <= '0;
      idx_q   <= '0;
      seg_q   <= SegBlank;
      an_q    <= AnReset;
    end else begin
      val_q   <= val_d;
      vld_q   <= vld_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      psc_q   <= psc_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign seg      = seg_q;
  assign an       = an_q;
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display with DIGITS=4, SCAN_DIV=4, ACTIVE_LOW=1.
module tb_seg_scan_display;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_val;
  logic       backspace;
  logic       clear;
  logic [7:0] seg;
  logic [3:0] an;
  logic [2:0] count;
  logic       overflow;

  int n_cmp = 0;
  int n_err = 0;

  seg_scan_display #(
    .DIGITS    (4),
    .SCAN_DIV  (4),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_valid(key_valid),
    .key_val  (key_val),
    .backspace(backspace),
    .clear    (clear),
    .seg      (seg),
    .an       (an),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic       kv;
    logic [3:0] kval;
    logic       bs;
    logic [2:0] exp_cnt;
    logic       exp_ov;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle of strobes; returns sampled #1 after the edge that performed the operation.
  task automatic apply(input logic clr, input logic kv, input logic [3:0] kval, input logic bs);
    clear     = clr;
    key_valid = kv;
    key_val   = kval;
    backspace = bs;
    @(posedge clk);
    #1;
    clear     = 1'b0;
    key_valid = 1'b0;
    backspace = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic key(input logic [3:0] v);
    apply(1'b0, 1'b1, v, 1'b0);
  endtask

  // Wait (bounded) until the given digit is being driven, then check its segments.
  task automatic check_slot(input int k, input logic [7:0] exp_seg);
    logic [3:0] exp_an;
    logic       found;
    exp_an = ~(4'b0001 << k);
    found  = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(posedge clk);
      #1;
      if (an === exp_an) found = 1'b1;
    end
    check($sformatf("slot%0d_seen", k), {31'd0, found}, 32'd1);
    if (found) check($sformatf("slot%0d_seg", k), {24'd0, seg}, {24'd0, exp_seg});
  endtask

  initial begin
    // clr kv kval bs | count ov
    vecs[0]  = '{1'b0, 1'b1, 4'h1, 1'b0, 3'd1, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 4'h2, 1'b0, 3'd2, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 4'h3, 1'b0, 3'd3, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 4'h0, 1'b1, 3'd2, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 4'h0, 1'b1, 3'd1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 4'h0, 1'b1, 3'd0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 4'h0, 1'b1, 3'd0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 4'h0, 1'b0, 3'd1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 4'h1, 1'b0, 3'd2, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 4'h2, 1'b0, 3'd3, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 4'h3, 1'b0, 3'd4, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 4'h4, 1'b0, 3'd4, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 4'h0, 1'b0, 3'd4, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 4'h5, 1'b1, 3'd4, 1'b1};
    vecs[14] = '{1'b1, 1'b0, 4'h0, 1'b0, 3'd0, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 4'h7, 1'b0, 3'd0, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 4'h5, 1'b0, 3'd1, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 4'h5, 1'b1, 3'd2, 1'b0};
    vecs[18] = '{1'b1, 1'b1, 4'h9, 1'b1, 3'd0, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 4'h0, 1'b1, 3'd0, 1'b0};

    rst       = 1'b1;
    key_valid = 1'b0;
    key_val   = 4'h0;
    backspace = 1'b0;
    clear     = 1'b0;

    // Reset state, sampled while reset is still asserted.
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_seg", {24'd0, seg}, 32'hFF);
    check("rst_an", {28'd0, an}, 32'hE);
    check("rst_count", {29'd0, count}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    rst = 1'b0;

    // Idle scan: an at k cycles after the last reset edge shows idx floor((k-1)/4) mod 4.
    for (int k = 1; k <= 20; k++) begin
      logic [3:0] exp_an;
      @(posedge clk);
      #1;
      exp_an = ~(4'b0001 << (((k - 1) / 4) % 4));
      check($sformatf("scan_an_k%0d", k), {28'd0, an}, {28'd0, exp_an});
      check($sformatf("scan_seg_k%0d", k), {24'd0, seg}, 32'hFF);
    end

    // Table-driven buffer operations.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      apply(vecs[i].clr, vecs[i].kv, vecs[i].kval, vecs[i].bs);
      check($sformatf("vec%0d_count", i), {29'd0, count}, {29'd0, vecs[i].exp_cnt});
      check($sformatf("vec%0d_ovf", i), {31'd0, overflow}, {31'd0, vecs[i].exp_ov});
    end

    // Keys 1,2,3 -> slots B0 A4 F9 FF.
    do_reset();
    key(4'h1);
    key(4'h2);
    key(4'h3);
    check("k123_count", {29'd0, count}, 32'd3);
    check_slot(0, 8'hB0);
    check_slot(1, 8'hA4);
    check_slot(2, 8'hF9);
    check_slot(3, 8'hFF);

    // Overflow: keys 0..4, pulse only after key 4.
    do_reset();
    for (int v = 0; v < 4; v++) begin
      key(v[3:0]);
      check($sformatf("ovf_pre%0d", v), {31'd0, overflow}, 32'd0);
    end
    key(4'h4);
    check("ovf_pulse", {31'd0, overflow}, 32'd1);
    check("ovf_count", {29'd0, count}, 32'd4);
    @(posedge clk);
    #1;
    check("ovf_drop", {31'd0, overflow}, 32'd0);
    check_slot(0, 8'h99);
    check_slot(1, 8'hB0);
    check_slot(2, 8'hA4);
    check_slot(3, 8'hF9);

    // Backspace, then backspace on an empty buffer.
    do_reset();
    key(4'h1);
    key(4'h2);
    key(4'h3);
    apply(1'b0, 1'b0, 4'h0, 1'b1);
    check("bs_count", {29'd0, count}, 32'd2);
    check_slot(0, 8'hA4);
    check_slot(1, 8'hF9);
    check_slot(2, 8'hFF);
    apply(1'b1, 1'b0, 4'h0, 1'b0);
    apply(1'b0, 1'b0, 4'h0, 1'b1);
    check("bs_empty_count", {29'd0, count}, 32'd0);
    check("bs_empty_ovf", {31'd0, overflow}, 32'd0);
    check_slot(0, 8'hFF);

    // clear + key_valid together: clear wins.
    key(4'h8);
    apply(1'b1, 1'b1, 4'h6, 1'b0);
    check("clrkey_count", {29'd0, count}, 32'd0);
    for (int s = 0; s < 4; s++) check_slot(s, 8'hFF);

    // key_valid(5) + backspace from count 1: key wins.
    key(4'h1);
    apply(1'b0, 1'b1, 4'h5, 1'b1);
    check("keybs_count", {29'd0, count}, 32'd2);
    check_slot(0, 8'h92);
    check_slot(1, 8'hF9);

    // Reset with key_valid during scan slot 2.
    key(4'h3);
    check_slot(2, 8'hF9);
    rst       = 1'b1;
    key_valid = 1'b1;
    key_val   = 4'h7;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    key_valid = 1'b0;
    check("midrst_count", {29'd0, count}, 32'd0);
    check("midrst_an", {28'd0, an}, 32'hE);
    check("midrst_seg", {24'd0, seg}, 32'hFF);
    check("midrst_ovf", {31'd0, overflow}, 32'd0);
    @(posedge clk);
    #1;
    check("midrst_ovf2", {31'd0, overflow}, 32'd0);
    check("midrst_an2", {28'd0, an}, 32'hE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seg_scan_display.md
SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

Interface
REQ-001 SHALL provide parameter DIGITS, default 8: number of display digits and buffer depth; legal range 1..16.
REQ-002 SHALL provide parameter SCAN_DIV, default 100000: clock cycles per digit scan slot; legal range >= 2.
REQ-003 SHALL provide parameter ACTIVE_LOW, default 1: 1 = segment and anode outputs are active-low; 0 = both active-high.
REQ-004 SHALL have one clock and a synchronous, active-high reset; no other clock or asynchronous input.
REQ-005 clk  input  1  system clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 key_valid  input  1  single-cycle strobe: key_val holds a new digit.
REQ-008 key_val  input  4  hex digit 0x0..0xF entered.
REQ-009 backspace  input  1  single-cycle strobe: remove newest digit.
REQ-010 clear  input  1  single-cycle strobe: empty buffer.
REQ-011 seg  output  8  segment drive {dp,g,f,e,d,c,b,a}, registered.
REQ-012 an  output  DIGITS  digit enable, one-hot, registered.
REQ-013 count  output  clog2(DIGITS+1)  number of valid digits held.
REQ-014 overflow  output  1  one-cycle pulse: oldest digit discarded.

Function
REQ-015 Buffer SHALL hold DIGITS entries d[0..DIGITS-1] (4-bit value + valid bit); d[0] = newest = rightmost digit, an[0].
REQ-016 key_valid in cycle N SHALL shift d[i]<=d[i-1], load d[0]<=key_val valid, count<=min(count+1,DIGITS), all visible at N+1.
REQ-017 key_valid with count==DIGITS SHALL discard d[DIGITS-1] and assert overflow for exactly cycle N+1; count stays DIGITS.
REQ-018 backspace with count>0 SHALL shift d[i]<=d[i+1], invalidate d[DIGITS-1], decrement count; with count==0 it SHALL be a no-op.
REQ-019 clear SHALL invalidate all entries and set count=0 in the next cycle.
REQ-020 Simultaneous strobes SHALL resolve by priority clear > key_valid > backspace; exactly one operation per cycle, losers ignored.
REQ-021 Prescaler SHALL count 0..SCAN_DIV-1; at SCAN_DIV-1 it wraps to 0 and scan index advances by 1, wrapping DIGITS-1 -> 0.
REQ-022 Scan index states SHALL be 0..DIGITS-1 only; DIGITS==1 keeps index 0 permanently.
REQ-023 Active-low segment codes SHALL be 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90 A:88 B:83 C:C6 D:A1 E:86 F:8E; blank FF; dp always off.
REQ-024 seg SHALL be code of d[idx] if valid, blank otherwise; an SHALL enable bit idx only; both registered, one cycle after idx/buffer change.
REQ-025 ACTIVE_LOW=0 SHALL bitwise-invert both seg and an relative to REQ-023/REQ-024.
REQ-026 Buffer edits SHALL NOT disturb prescaler or scan index.

Reset
REQ-027 rst SHALL clear all entries, count=0, overflow=0, prescaler=0, idx=0 on the next edge, overriding all strobes.
REQ-028 During and after reset seg SHALL be blank and an SHALL enable digit 0 (ACTIVE_LOW=1: seg=FF, an=...1110).
REQ-029 Reset asserted mid-scan or mid-operation SHALL abandon it; no overflow pulse after reset.

Verification (DIGITS=4, SCAN_DIV=4, ACTIVE_LOW=1)
REQ-030 Reset, hold idle -> seg=FF, an=1110, count=0; an sequence 1110,1101,1011,0111,1110 with each step 4 cycles.
REQ-031 Keys 1,2,3 -> count=3; slot0 seg=B0, slot1 A4, slot2 F9, slot3 FF.
REQ-032 Keys 0,1,2,3,4 -> overflow high one cycle after key 4 only; count=4; slots 0..3 = 99,B0,A4,F9.
REQ-033 Keys 1,2,3 then backspace -> count=2, slot0 A4, slot1 F9; backspace at count=0 -> no change, overflow=0.
REQ-034 clear+key_valid same cycle -> count=0, all slots FF; key_valid(5)+backspace same cycle from count=1 -> count=2, slot0=92.
REQ-035 rst asserted with key_valid during scan slot 2 -> next cycle count=0, an=1110, seg=FF.
